// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op bit indices
// and the decode-to-execute bundle layout.
// EXE_FORWARD_EN widens the hazard bus so decode can bypass ALU results.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 150;
    localparam int ES_TO_MS_BUS_WD = 71;
`ifdef EXE_FORWARD_EN
    localparam int HAZARD_BUS_WD   = 40;
`else
    localparam int HAZARD_BUS_WD   = 7;
`endif

    // One-hot ALU op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Decode bundle, MSB first, matching ds_to_es_bus bit for bit
    typedef struct packed {
        logic [11:0] alu_op;
        logic        load_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rj_value;
        logic [31:0] rkd_value;
        logic [31:0] pc;
    } ds_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Purely combinational ALU; alu_op is one-hot, all-zero op yields 0.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;

    assign w_add  = alu_src1 + alu_src2;
    assign w_sub  = alu_src1 - alu_src2;
    assign w_slt  = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
    assign w_sltu = {31'b0, (alu_src1 < alu_src2)};
    assign w_sll  = alu_src1 << alu_src2[4:0];
    assign w_srl  = alu_src1 >> alu_src2[4:0];
    assign w_sra  = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

    // Select the single active op's result by masking and OR-merging
    always_comb begin
        alu_result = ({32{alu_op[ALU_ADD ]}} & w_add)
                   | ({32{alu_op[ALU_SUB ]}} & w_sub)
                   | ({32{alu_op[ALU_SLT ]}} & w_slt)
                   | ({32{alu_op[ALU_SLTU]}} & w_sltu)
                   | ({32{alu_op[ALU_AND ]}} & (alu_src1 & alu_src2))
                   | ({32{alu_op[ALU_NOR ]}} & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_OR  ]}} & (alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_XOR ]}} & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[ALU_SLL ]}} & w_sll)
                   | ({32{alu_op[ALU_SRL ]}} & w_srl)
                   | ({32{alu_op[ALU_SRA ]}} & w_sra)
                   | ({32{alu_op[ALU_LUI ]}} & alu_src2);
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers the decode bundle, runs the ALU, issues the
// data-SRAM request and publishes its destination on the hazard bus.
// EXE_FORWARD_EN appends {res_from_mem, alu_result} to the hazard bus.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [HAZARD_BUS_WD-1:0]   es_hazard_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    logic        r_es_valid;
    ds_bus_t     r_ds;
    logic        w_ready_go;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_alu_result;

    assign w_ready_go     = 1'b1;
    assign es_allowin     = !r_es_valid || (w_ready_go && ms_allowin);
    assign es_to_ms_valid = r_es_valid && w_ready_go;

    // Stage valid flag advances whenever the stage can accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    // Bundle captured only on an accepted valid transfer; held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ds <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            r_ds <= ds_bus_t'(ds_to_es_bus);
        end
    end

    assign w_src1 = r_ds.src1_is_pc  ? r_ds.pc  : r_ds.rj_value;
    assign w_src2 = r_ds.src2_is_imm ? r_ds.imm : r_ds.rkd_value;

    exe_stage_alu u_alu (
        .alu_op     (r_ds.alu_op),
        .alu_src1   (w_src1),
        .alu_src2   (w_src2),
        .alu_result (w_alu_result)
    );

    assign es_to_ms_bus = {r_ds.load_op, r_ds.gr_we, r_ds.dest, w_alu_result, r_ds.pc};

    assign data_sram_en    = r_es_valid && (r_ds.load_op || r_ds.mem_we);
    assign data_sram_we    = {4{r_es_valid && r_ds.mem_we}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = r_ds.rkd_value;

`ifdef EXE_FORWARD_EN
    assign es_hazard_bus = {r_es_valid, r_ds.gr_we, r_ds.dest, r_ds.load_op, w_alu_result};
`else
    assign es_hazard_bus = {r_es_valid, r_ds.gr_we, r_ds.dest};
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: a spec-level model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_exe_stage;

`ifdef EXE_FORWARD_EN
    localparam int HW = 40;
`else
    localparam int HW = 7;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ms_allowin;
    logic          es_allowin;
    logic          ds_to_es_valid;
    logic [149:0]  ds_to_es_bus;
    logic          es_to_ms_valid;
    logic [70:0]   es_to_ms_bus;
    logic [HW-1:0] es_hazard_bus;
    logic          data_sram_en;
    logic [3:0]    data_sram_we;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;

    int errors = 0;
    int checks = 0;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_hazard_bus   (es_hazard_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [149:0] mk(input logic [11:0] op, input logic ld, input logic s1pc,
                                        input logic s2imm, input logic grwe, input logic memwe,
                                        input logic [4:0] dest, input logic [31:0] imm,
                                        input logic [31:0] rj, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        return {op, ld, s1pc, s2imm, grwe, memwe, dest, imm, rj, rkd, pc};
    endfunction

    // Reference ALU: find the active op, then apply its arithmetic rule
    function automatic logic [31:0] model_alu(input logic [11:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int k = -1;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        for (int i = 0; i < 12; i++) if (op[i]) k = i;
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'(sa >>> b[4:0]);
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Model state: whether the stage holds a bundle, and which bundle
    logic         m_valid;
    logic [149:0] m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_b     <= '0;
        end else if (!m_valid || ms_allowin) begin
            m_valid <= ds_to_es_valid;
            if (ds_to_es_valid) m_b <= ds_to_es_bus;
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        logic [31:0]   a, b, r;
        logic [HW-1:0] hz;
        forever begin
            @(posedge clk);
            #3;
            if (!reset) begin
                a = m_b[136] ? m_b[31:0] : m_b[95:64];
                b = m_b[135] ? m_b[127:96] : m_b[63:32];
                r = model_alu(m_b[149:138], a, b);
`ifdef EXE_FORWARD_EN
                hz = {m_valid, m_b[134], m_b[132:128], m_b[137], r};
`else
                hz = {m_valid, m_b[134], m_b[132:128]};
`endif
                chk("m_allowin", 64'(es_allowin), 64'(!m_valid || ms_allowin));
                chk("m_to_ms_valid", 64'(es_to_ms_valid), 64'(m_valid));
                chk("m_to_ms_bus", 64'(es_to_ms_bus[70:32]), 64'({m_b[137], m_b[134], m_b[132:128], r}));
                chk("m_to_ms_pc", 64'(es_to_ms_bus[31:0]), 64'(m_b[31:0]));
                chk("m_hazard", 64'(es_hazard_bus), 64'(hz));
                chk("m_sram_en", 64'(data_sram_en), 64'(m_valid && (m_b[137] || m_b[133])));
                chk("m_sram_we", 64'(data_sram_we), 64'({4{m_valid && m_b[133]}}));
                chk("m_sram_addr", 64'(data_sram_addr), 64'(r));
                chk("m_sram_wdata", 64'(data_sram_wdata), 64'(m_b[63:32]));
            end
        end
    end

    task automatic send(input logic [149:0] b);
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
    endtask

    task automatic settle();
        @(posedge clk);
        #4;
    endtask

    // ALU vector table: op, src1_is_pc, src2_is_imm, rj, rkd, imm, pc, expected
    logic [11:0] t_op  [13] = '{12'h400, 12'h004, 12'h008, 12'h002, 12'h010, 12'h020, 12'h040,
                                12'h080, 12'h100, 12'h200, 12'h800, 12'h000, 12'h001};
    logic        t_pc  [13] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};
    logic        t_imm [13] = '{1,0,0,0,0,0,0,0,0,0,1,0,1};
    logic [31:0] t_rj  [13] = '{32'h80000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'hF0F0F0F0,
                                32'hF0F0F0F0, 32'h12340000, 32'hFFFF0000, 32'h3, 32'h80000000,
                                32'h11111111, 32'h12345678, 32'h0};
    logic [31:0] t_rkd [13] = '{32'h0, 32'h1, 32'h1, 32'h7, 32'h0FF00FF0, 32'h0F0F0000,
                                32'h00005678, 32'h0F0F0F0F, 32'h24, 32'h1F, 32'h0, 32'h1, 32'h0};
    logic [31:0] t_im  [13] = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'hABCDE000, 32'h0, 32'h8};
    logic [31:0] t_exp [13] = '{32'hF8000001, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h00F000F0,
                                32'h00000F0F, 32'h12345678, 32'hF0F00F0F, 32'h30, 32'h1,
                                32'hABCDE000, 32'h0, 32'h1C000018};

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("allowin_after_reset", 64'(es_allowin), 64'd1);
        chk("valid_after_reset", 64'(es_to_ms_valid), 64'd0);

        // add with immediate
        send(mk(12'h001, 0, 0, 1, 1, 0, 5'd5, 32'h1, 32'h7FFFFFFF, 32'h0, 32'h1C000000));
        settle();
        chk("add_imm_result", 64'(es_to_ms_bus[63:32]), 64'h80000000);
        chk("add_imm_hazard", 64'(es_hazard_bus[HW-1:HW-7]), 64'b1100101);

        // back-to-back ALU vectors
        for (int i = 0; i < 13; i++) begin
            send(mk(t_op[i], 0, t_pc[i], t_imm[i], 1, 0, 5'(i + 1), t_im[i], t_rj[i], t_rkd[i],
                    32'h1C000010));
            settle();
            chk($sformatf("alu_vec%0d", i), 64'(es_to_ms_bus[63:32]), 64'(t_exp[i]));
        end

        // store word
        send(mk(12'h001, 0, 0, 1, 0, 1, 5'd0, 32'hFFFFFFFC, 32'h1000, 32'hDEADBEEF, 32'h1C000020));
        settle();
        chk("st_en", 64'(data_sram_en), 64'd1);
        chk("st_we", 64'(data_sram_we), 64'hF);
        chk("st_addr", 64'(data_sram_addr), 64'h00000FFC);
        chk("st_wdata", 64'(data_sram_wdata), 64'hDEADBEEF);

        // backpressure: new bundle offered while mem stage refuses
        @(negedge clk);
        ms_allowin     = 1'b0;
        ds_to_es_bus   = mk(12'h040, 0, 0, 0, 1, 0, 5'd7, 32'h0, 32'h00FF0000, 32'h000000FF, 32'h1C000024);
        ds_to_es_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("bp_allowin", 64'(es_allowin), 64'd0);
            chk("bp_valid_held", 64'(es_to_ms_valid), 64'd1);
            chk("bp_addr_held", 64'(data_sram_addr), 64'h00000FFC);
            chk("bp_we_held", 64'(data_sram_we), 64'hF);
        end
        @(negedge clk);
        ms_allowin = 1'b1;
        settle();
        chk("bp_release_result", 64'(es_to_ms_bus[63:32]), 64'h00FF00FF);
        chk("bp_release_dest", 64'(es_to_ms_bus[68:64]), 64'd7);
        chk("bp_release_sram_en", 64'(data_sram_en), 64'd0);

        // bubble
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        settle();
        chk("bubble_valid", 64'(es_to_ms_valid), 64'd0);
        chk("bubble_sram_en", 64'(data_sram_en), 64'd0);

        // load word
        send(mk(12'h001, 1, 0, 1, 1, 0, 5'd9, 32'h4, 32'h2000, 32'h0, 32'h1C000028));
        settle();
        chk("ld_en", 64'(data_sram_en), 64'd1);
        chk("ld_we", 64'(data_sram_we), 64'h0);
        chk("ld_res_from_mem", 64'(es_to_ms_bus[70]), 64'd1);
        chk("ld_addr", 64'(data_sram_addr), 64'h2004);
`ifdef EXE_FORWARD_EN
        chk("ld_fwd_rfm", 64'(es_hazard_bus[32]), 64'd1);
        chk("ld_fwd_result", 64'(es_hazard_bus[31:0]), 64'h2004);
`endif

        // asynchronous reset mid-cycle while the stage holds a load
        chk("pre_reset_valid", 64'(es_to_ms_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(es_to_ms_valid), 64'd0);
        chk("async_rst_sram_en", 64'(data_sram_en), 64'd0);
        chk("async_rst_hz_valid", 64'(es_hazard_bus[HW-1]), 64'd0);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("allowin_after_rst2", 64'(es_allowin), 64'd1);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the five-stage LoongArch-subset pipeline; sits directly downstream of id_stage and upstream of mem_stage.
- Registers the decode bundle and computes the ALU result.
- Issues the data-SRAM request for ld.w/st.w; publishes its destination on the hazard bus so decode can stall.
- Pipeline handshake is valid/allowin; ready_go is always 1.

Parameters:
- none (all widths come from the shared `define header)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ms_allowin  in  1  mem stage can accept
- es_allowin  out  1  this stage can accept
- ds_to_es_valid  in  1  decode presents valid bundle
- ds_to_es_bus  in  150  {alu_op[11:0], load_op, src1_is_pc, src2_is_imm, gr_we, mem_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0]}, MSB first
- es_to_ms_valid  out  1  bundle valid to mem stage
- es_to_ms_bus  out  71  {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
- es_hazard_bus  out  7 (40 with EXE_FORWARD_EN)  {es_valid, es_gr_we, es_dest[4:0]}
- data_sram_en  out  1  data memory access enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

Behaviour:
- es_valid register; async reset to 0. Bundle register resets to 0.
- es_ready_go = 1.
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- es_to_ms_valid = es_valid && es_ready_go.
- On the clock edge when es_allowin = 1: es_valid <= ds_to_es_valid.
- Bundle register loads only when ds_to_es_valid && es_allowin; otherwise it holds, including during a stall with es_valid = 1.
- Reset mid-operation: es_valid drops immediately (asynchronous). All outputs gated by es_valid go 0 in the same cycle.
- Operand selection:
  - src1 = src1_is_pc ? pc : rj_value
  - src2 = src2_is_imm ? imm : rkd_value
- alu_op one-hot; bit → result:
  - 0 add (wrap mod 2^32)
  - 1 sub
  - 2 signed slt → {31'b0, lt}
  - 3 unsigned sltu
  - 4 and
  - 5 nor
  - 6 or
  - 7 xor
  - 8 sll by src2[4:0]
  - 9 srl
  - 10 sra (sign-fill)
  - 11 lui: result = src2
  - All-zero alu_op → result 0.
  - Combinational, zero added latency. Result reaches the bus in the cycle after capture.
- Memory request:
  - data_sram_en = es_valid && (load_op || mem_we).
  - data_sram_we = {4{es_valid && mem_we}}.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rkd_value.
  - Request is re-asserted every cycle while stalled; idempotent for the synchronous SRAM.
- res_from_mem = load_op.
- Hazard bus:
  - es_valid field = es_valid.
  - es_gr_we = gr_we.
  - es_dest = dest.
  - dest 0 is passed as-is; decode handles r0.
- Simultaneous ms_allowin = 0 with a valid upstream bundle: es_allowin = 0 and the bundle is not captured.

Optional Feature:
- EXE_FORWARD_EN defined:
  - es_hazard_bus widens to 40 bits: {es_valid, es_gr_we, es_dest[4:0], es_res_from_mem, alu_result[31:0]}.
  - Decode can bypass ALU results and stall only when es_res_from_mem = 1.
- Undefined: 7-bit bus exactly as listed above.
- HAZARD_BUS_WD in the shared header switches on the same macro.

Decomposition:
- Shared mycpu.h holds:
  - DS_TO_ES_BUS_WD = 150
  - ES_TO_MS_BUS_WD = 71
  - HAZARD_BUS_WD (7/40)
  - ALU op bit indices
- Sub-module alu: purely combinational.
  - Inputs: alu_op[11:0], alu_src1[31:0], alu_src2[31:0]
  - Output: alu_result[31:0]
- exe_stage keeps only the handshake, registers, muxing and SRAM/hazard glue.

Test Plan:
- Reset:
  - Assert reset asynchronously mid-cycle with es_valid = 1 → es_valid, es_to_ms_valid and data_sram_en fall before the next edge.
  - After release, es_allowin = 1.
- Add with immediate:
  - Bundle alu_op = 0x001, src2_is_imm = 1, rj_value = 0x7FFFFFFF, imm = 1, dest = 5 → next cycle alu_result = 0x80000000, es_hazard_bus = {1,1,5}.
- Shifts and slt:
  - sra of 0x80000010 by imm 4 → 0xF8000001.
  - slt of -1 vs 1 → 1.
  - sltu of 0xFFFFFFFF vs 1 → 0.
- Store:
  - st.w with rj_value = 0x1000, imm = 0xFFFFFFFC, rkd_value = 0xDEADBEEF → data_sram_en = 1, we = 0xF, addr = 0x00000FFC, wdata = 0xDEADBEEF.
- Backpressure:
  - Hold ms_allowin = 0 for 3 cycles while decode offers a new bundle → es_allowin = 0, bundle and outputs unchanged.
  - Release → the new bundle is captured on the following edge, with no loss or duplication.
- Bubble:
  - ds_to_es_valid = 0 with ms_allowin = 1 → es_valid = 0 next cycle, data_sram_en = 0.
  - With EXE_FORWARD_EN defined, a ld.w sets the res_from_mem hazard field to 1.
